// File: rtl/eth_pkg.sv
// Shared Ethernet framing types and constants for the frame builder.
package eth_pkg;

    typedef logic [7:0]  byte_t;
    typedef logic [47:0] mac_addr_t;

    localparam int          ETH_HEADER_LEN  = 14;
    localparam int          ETH_MIN_PAYLOAD = 46;
    localparam logic [15:0] ETHERTYPE_IPV4  = 16'h0800;
    localparam int          ETHERTYPE_POS   = 12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_PAD
    } framer_state_t;

endpackage

// File: rtl/eth_framer.sv
// Ethernet frame builder: prepends dst/src MAC + EtherType to a byte stream.
// Define ETH_FRAMER_PAD_EN to zero-pad runt payloads to the 46-byte minimum.
module eth_framer
    import eth_pkg::*;
#(
    parameter logic [15:0] ETHERTYPE = ETHERTYPE_IPV4,
    parameter logic [47:0] SRC_MAC   = 48'h02_00_00_00_00_01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [47:0] dst_mac,
    input  logic        pl_valid,
    input  logic [7:0]  pl_data,
    input  logic        pl_eof,
    output logic        pl_ready,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_eof
);

    framer_state_t state_reg;
    logic [3:0]    hdr_cnt_reg;
    mac_addr_t     dst_reg;
    logic          tx_valid_reg;
    byte_t         tx_data_reg;
    logic          tx_eof_reg;

    logic  load_ok;
    logic  pl_accept;
    byte_t hdr_bytes [16];

    // Header byte mux, indexed by the header counter; unused slots read as zero.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_hdr
            if (gi < 6) begin : g_dst
                assign hdr_bytes[gi] = dst_reg[8*(5-gi) +: 8];
            end else if (gi < ETHERTYPE_POS) begin : g_src
                assign hdr_bytes[gi] = SRC_MAC[8*(ETHERTYPE_POS-1-gi) +: 8];
            end else if (gi < ETH_HEADER_LEN) begin : g_type
                assign hdr_bytes[gi] = ETHERTYPE[8*(ETH_HEADER_LEN-1-gi) +: 8];
            end else begin : g_none
                assign hdr_bytes[gi] = '0;
            end
        end
    endgenerate

    assign load_ok   = !tx_valid_reg || tx_ready;
    assign pl_ready  = (state_reg == ST_PAYLOAD) && load_ok;
    assign pl_accept = pl_ready && pl_valid;

`ifdef ETH_FRAMER_PAD_EN
    logic [5:0] pl_cnt_reg;
    logic [5:0] pl_cnt_next;
    logic       min_reached;

    // Saturating count: once 46 bytes are in, the frame never needs padding.
    assign pl_cnt_next = (pl_cnt_reg == 6'(ETH_MIN_PAYLOAD)) ? pl_cnt_reg : pl_cnt_reg + 6'd1;
    assign min_reached = (pl_cnt_next == 6'(ETH_MIN_PAYLOAD));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            hdr_cnt_reg  <= '0;
            dst_reg      <= '0;
            tx_valid_reg <= 1'b0;
            tx_data_reg  <= '0;
            tx_eof_reg   <= 1'b0;
`ifdef ETH_FRAMER_PAD_EN
            pl_cnt_reg   <= '0;
`endif
        end else begin
            if (tx_ready) begin
                tx_valid_reg <= 1'b0;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (pl_valid) begin
                        dst_reg     <= dst_mac;
                        hdr_cnt_reg <= '0;
`ifdef ETH_FRAMER_PAD_EN
                        pl_cnt_reg  <= '0;
`endif
                        state_reg   <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (load_ok) begin
                        tx_valid_reg <= 1'b1;
                        tx_data_reg  <= hdr_bytes[hdr_cnt_reg];
                        tx_eof_reg   <= 1'b0;
                        hdr_cnt_reg  <= hdr_cnt_reg + 4'd1;
                        if (hdr_cnt_reg == 4'(ETH_HEADER_LEN - 1)) begin
                            state_reg <= ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (pl_accept) begin
                        tx_valid_reg <= 1'b1;
                        tx_data_reg  <= pl_data;
`ifdef ETH_FRAMER_PAD_EN
                        pl_cnt_reg   <= pl_cnt_next;
                        tx_eof_reg   <= pl_eof && min_reached;
                        if (pl_eof) begin
                            state_reg <= min_reached ? ST_IDLE : ST_PAD;
                        end
`else
                        tx_eof_reg   <= pl_eof;
                        if (pl_eof) begin
                            state_reg <= ST_IDLE;
                        end
`endif
                    end
                end
`ifdef ETH_FRAMER_PAD_EN
                ST_PAD: begin
                    if (load_ok) begin
                        tx_valid_reg <= 1'b1;
                        tx_data_reg  <= '0;
                        tx_eof_reg   <= min_reached;
                        pl_cnt_reg   <= pl_cnt_next;
                        if (min_reached) begin
                            state_reg <= ST_IDLE;
                        end
                    end
                end
`endif
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign tx_valid = tx_valid_reg;
    assign tx_data  = tx_data_reg;
    assign tx_eof   = tx_eof_reg;

endmodule
